// File: rtl/motor_step_gen_if.sv
// Command/status bundle between the axis command decoder (master) and
// one motor_step_gen instance (slave).
interface motor_step_gen_if #(
  parameter int DIV_W = 20,
  parameter int POS_W = 32
);
  logic                    stepClockEna;
  logic [DIV_W-1:0]        divider;
  logic                    moveDirInvers;
  logic signed [POS_W-1:0] target_pos;
  logic                    target_load;
  logic                    pos_load;
  logic signed [POS_W-1:0] pos_value;
  logic                    abort;
  logic                    dir;
  logic                    step;
  logic signed [POS_W-1:0] cur_position;
  logic                    busy;
  logic                    done;
  logic                    aborted;

  modport master (
    output stepClockEna, divider, moveDirInvers, target_pos, target_load,
           pos_load, pos_value, abort,
    input  dir, step, cur_position, busy, done, aborted
  );

  modport slave (
    input  stepClockEna, divider, moveDirInvers, target_pos, target_load,
           pos_load, pos_value, abort,
    output dir, step, cur_position, busy, done, aborted
  );
endinterface

// File: rtl/motor_step_gen.sv
// Step/direction pulse generator for one stepper axis driving to an absolute target.
// Define MOTOR_RAMP_EN to build the trapezoidal acceleration/deceleration profile.
module motor_step_gen #(
  parameter int DIV_W         = 20,
  parameter int POS_W         = 32,
  parameter int DIR_SETUP_CYC = 50,
  parameter int RAMP_LEN      = 64,
  parameter int RAMP_INC      = 256
) (
  input logic             CLK_50MHZ,
  input logic             reset,
  motor_step_gen_if.slave bus
);

  localparam int SETUP_W = (DIR_SETUP_CYC > 1) ? $clog2(DIR_SETUP_CYC) : 1;
  localparam logic [SETUP_W-1:0] SETUP_INIT = SETUP_W'(DIR_SETUP_CYC - 1);
  localparam logic [POS_W:0]     ONE_P = (POS_W+1)'(1);
  localparam logic [POS_W-1:0]   ONE_Q = POS_W'(1);
  localparam logic [DIV_W-1:0]   ONE_D = DIV_W'(1);

  if (DIR_SETUP_CYC < 1) begin : g_chkSetup
    $error("motor_step_gen: DIR_SETUP_CYC must be at least 1");
  end
  if (RAMP_LEN < 0 || RAMP_INC < 0) begin : g_chkRamp
    $error("motor_step_gen: RAMP_LEN and RAMP_INC must be non-negative");
  end

  typedef enum logic [1:0] {IDLE, SETUP, STEP_HI, STEP_LO} state_t;

  state_t                  r_state;
  logic                    r_dirInt;
  logic                    r_step;
  logic signed [POS_W-1:0] r_pos;
  logic [POS_W:0]          r_stepsLeft;
  logic [DIV_W-1:0]        r_cnt;
  logic [DIV_W-1:0]        r_loTicks;
  logic [SETUP_W-1:0]      r_setupCnt;
  logic                    r_abortPend;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_aborted;

  logic [POS_W:0]   w_delta;
  logic [POS_W:0]   w_absDelta;
  logic [POS_W:0]   w_leftBefore;
  logic [POS_W:0]   w_leftAfter;
  logic             w_newDir;
  logic             w_tick;
  logic             w_abortReq;
  logic             w_enterHi;
  logic [DIV_W-1:0] w_baseE;
  logic [DIV_W-1:0] w_effE;
  logic [DIV_W-1:0] w_hiTicks;
  logic [DIV_W-1:0] w_loTicks;

  // Delta is one bit wider than the position so a full-range move cannot overflow.
  assign w_delta      = {bus.target_pos[POS_W-1], bus.target_pos} - {r_pos[POS_W-1], r_pos};
  assign w_absDelta   = w_delta[POS_W] ? (~w_delta + ONE_P) : w_delta;
  assign w_newDir     = ~w_delta[POS_W];
  assign w_tick       = bus.stepClockEna;
  assign w_abortReq   = bus.abort | r_abortPend;
  assign w_leftBefore = (r_state == IDLE) ? w_absDelta : r_stepsLeft;
  assign w_leftAfter  = w_leftBefore - ONE_P;
  assign w_baseE      = (bus.divider == '0) ? ONE_D : bus.divider;

`ifdef MOTOR_RAMP_EN
  localparam logic [POS_W:0] RAMP_LEN_P = (POS_W+1)'(RAMP_LEN);
  localparam logic [63:0]    E_MAX      = (64'(1) << DIV_W) - 64'(1);

  logic [POS_W:0] r_issued;
  logic [POS_W:0] w_issued;
  logic [POS_W:0] w_rampR;
  logic [63:0]    w_rampSum;

  // Ramp position is the distance to the nearer end of the move, capped at RAMP_LEN.
  always_comb begin
    w_issued = (r_state == IDLE) ? '0 : r_issued;
    w_rampR  = w_issued;
    if (w_leftAfter < w_rampR) w_rampR = w_leftAfter;
    if (RAMP_LEN_P < w_rampR)  w_rampR = RAMP_LEN_P;
    w_rampSum = 64'(w_baseE) + 64'(RAMP_LEN_P - w_rampR) * 64'(RAMP_INC);
    w_effE    = (w_rampSum > E_MAX) ? {DIV_W{1'b1}} : DIV_W'(w_rampSum);
  end
`else
  assign w_effE = w_baseE;
`endif

  assign w_hiTicks = DIV_W'(({1'b0, w_effE} + (DIV_W+1)'(2)) >> 1);
  assign w_loTicks = DIV_W'(({1'b0, w_effE} + (DIV_W+1)'(1)) >> 1);

  always_comb begin
    w_enterHi = 1'b0;
    case (r_state)
      IDLE:    w_enterHi = bus.target_load && !bus.pos_load && !bus.abort &&
                           (w_absDelta != '0) && (w_newDir == r_dirInt);
      SETUP:   w_enterHi = w_tick && (r_setupCnt == '0) && !w_abortReq;
      STEP_LO: w_enterHi = w_tick && (r_cnt <= ONE_D) && (r_stepsLeft != '0) && !w_abortReq;
      default: w_enterHi = 1'b0;
    endcase
  end

  // Step-high entry is shared by IDLE, SETUP and STEP_LO, so it is applied after the case.
  always_ff @(posedge CLK_50MHZ) begin
    if (reset) begin
      r_state     <= IDLE;
      r_dirInt    <= 1'b1;
      r_step      <= 1'b0;
      r_pos       <= '0;
      r_stepsLeft <= '0;
      r_cnt       <= '0;
      r_loTicks   <= '0;
      r_setupCnt  <= '0;
      r_abortPend <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
`ifdef MOTOR_RAMP_EN
      r_issued    <= '0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        IDLE: begin
          r_abortPend <= 1'b0;
`ifdef MOTOR_RAMP_EN
          r_issued    <= '0;
`endif
          if (bus.pos_load) begin
            r_pos <= bus.pos_value;
          end else if (bus.target_load && !bus.abort) begin
            if (w_absDelta == '0) begin
              r_done <= 1'b1;
            end else if (w_newDir != r_dirInt) begin
              r_dirInt    <= w_newDir;
              r_state     <= SETUP;
              r_busy      <= 1'b1;
              r_setupCnt  <= SETUP_INIT;
              r_stepsLeft <= w_absDelta;
            end
          end
        end
        // No pulse has started yet, so an abort here ends the move right away.
        SETUP: begin
          if (w_abortReq) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
          end else if (r_setupCnt != '0) begin
            r_setupCnt <= r_setupCnt - SETUP_W'(1);
          end
        end
        STEP_HI: begin
          if (bus.abort) r_abortPend <= 1'b1;
          if (w_tick) begin
            if (r_cnt <= ONE_D) begin
              r_step  <= 1'b0;
              r_state <= STEP_LO;
              r_cnt   <= r_loTicks;
            end else begin
              r_cnt <= r_cnt - ONE_D;
            end
          end
        end
        STEP_LO: begin
          if (bus.abort) r_abortPend <= 1'b1;
          if (w_tick) begin
            if (r_cnt > ONE_D) begin
              r_cnt <= r_cnt - ONE_D;
            end else if (!w_enterHi) begin
              r_state   <= IDLE;
              r_busy    <= 1'b0;
              r_done    <= (r_stepsLeft == '0);
              r_aborted <= (r_stepsLeft != '0);
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_enterHi) begin
        r_state     <= STEP_HI;
        r_busy      <= 1'b1;
        r_step      <= 1'b1;
        r_pos       <= r_dirInt ? (r_pos + ONE_Q) : (r_pos - ONE_Q);
        r_stepsLeft <= w_leftAfter;
        r_cnt       <= w_hiTicks;
        r_loTicks   <= w_loTicks;
`ifdef MOTOR_RAMP_EN
        r_issued    <= (w_issued < RAMP_LEN_P) ? (w_issued + ONE_P) : w_issued;
`endif
      end
    end
  end

  assign bus.dir          = r_dirInt ^ bus.moveDirInvers;
  assign bus.step         = r_step;
  assign bus.cur_position = r_pos;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.aborted      = r_aborted;

endmodule

// File: tb/tb_motor_step_gen.sv
// Directed bench for motor_step_gen: expected step pulses are queued when a move is
// launched and checked by a pulse monitor as the DUT produces them.
module tb_motor_step_gen;

  localparam int DIV_W = 20;
  localparam int POS_W = 32;
  localparam int DSC   = 50;
  localparam int RLEN  = 2;
  localparam int RINC  = 4;
  localparam longint EMAX = (longint'(1) << DIV_W) - 1;
`ifdef MOTOR_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif

  typedef struct {
    int   hi;
    int   lo;
    logic dirPin;
  } pulse_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   doneCnt;
  int   abortCnt;
  int   phase;
  bit   enaDiv;
  bit   monEnable;
  longint modelPos;
  pulse_t expQ[$];

  bit   inHigh;
  bit   inLow;
  int   hiCnt;
  int   loCnt;
  logic pulseDir;

  motor_step_gen_if #(.DIV_W(DIV_W), .POS_W(POS_W)) bus ();

  motor_step_gen #(
    .DIV_W(DIV_W), .POS_W(POS_W), .DIR_SETUP_CYC(DSC),
    .RAMP_LEN(RLEN), .RAMP_INC(RINC)
  ) dut (
    .CLK_50MHZ(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic longint effDiv(input longint d, input longint issued, input longint remAfter);
    longint e;
    longint r;
    e = (d == 0) ? 1 : d;
    if (RAMP_ON) begin
      r = issued;
      if (remAfter < r) r = remAfter;
      if (RLEN < r) r = RLEN;
      e = e + (RLEN - r) * RINC;
      if (e > EMAX) e = EMAX;
    end
    return e;
  endfunction

  // In divided-enable mode only one clock in four is a tick.
  task automatic cycle();
    @(negedge clk);
    phase = (phase + 1) % 4;
    bus.stepClockEna = !enaDiv || (phase == 0);
  endtask

  task automatic applyStimulus(input longint target, input int nPulses);
    longint delta;
    longint absDelta;
    longint e;
    logic   newDir;
    int     cpt;
    pulse_t p;
    delta = target - modelPos;
    cpt = enaDiv ? 4 : 1;
    if (delta != 0) begin
      newDir   = (delta > 0);
      absDelta = newDir ? delta : -delta;
      for (int i = 0; i < nPulses && i < absDelta; i++) begin
        e = effDiv(longint'(bus.divider), i, absDelta - 1 - i);
        p.hi = int'((e + 2) / 2) * cpt;
        p.lo = int'((e + 1) / 2) * cpt;
        p.dirPin = newDir ^ bus.moveDirInvers;
        expQ.push_back(p);
        modelPos += newDir ? 1 : -1;
      end
    end
    if (enaDiv) begin
      while (phase != 0) cycle();
    end
    bus.target_pos  = POS_W'(target);
    bus.target_load = 1'b1;
    cycle();
    bus.target_load = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int bound);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < bound) begin
      cycle();
      n++;
    end
    checkOutput({tag, "_idle"}, bus.busy, 0);
    cycle();
  endtask

  task automatic finishPulse();
    pulse_t p;
    checks++;
    assert (expQ.size() > 0) else begin
      errors++;
      $error("[TB] FAIL extraPulse: observed hi=%0d lo=%0d with no pulse expected", hiCnt, loCnt);
    end
    if (expQ.size() > 0) begin
      p = expQ.pop_front();
      checkOutput("pulseHigh", hiCnt, p.hi);
      checkOutput("pulseLow", loCnt, p.lo);
      checkOutput("pulseDir", pulseDir, p.dirPin);
    end
    inHigh = 1'b0;
    inLow  = 1'b0;
  endtask

  // Measures each step pulse in clocks: high time, then low time until the next rise or idle.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      doneCnt++;
      checkOutput("busyAtDone", bus.busy, 0);
    end
    if (bus.aborted === 1'b1) begin
      abortCnt++;
      checkOutput("busyAtAbort", bus.busy, 0);
    end
    if (!monEnable) begin
      inHigh = 1'b0;
      inLow  = 1'b0;
    end else if (bus.step === 1'b1) begin
      if (inLow) finishPulse();
      if (!inHigh) begin
        inHigh   = 1'b1;
        hiCnt    = 0;
        loCnt    = 0;
        pulseDir = bus.dir;
      end
      hiCnt++;
    end else if (inHigh || inLow) begin
      if (bus.busy !== 1'b1) begin
        finishPulse();
      end else begin
        inHigh = 1'b0;
        inLow  = 1'b1;
        loCnt++;
      end
    end
  end

  initial begin
    int n;
    int rises;
    int doneBase;
    int abortBase;
    logic prevStep;

    errors = 0; checks = 0; doneCnt = 0; abortCnt = 0;
    phase = 0; enaDiv = 1'b0; monEnable = 1'b0; modelPos = 0;
    reset = 1'b1;
    bus.stepClockEna  = 1'b1;
    bus.divider       = DIV_W'(3);
    bus.moveDirInvers = 1'b0;
    bus.target_pos    = '0;
    bus.target_load   = 1'b0;
    bus.pos_load      = 1'b0;
    bus.pos_value     = '0;
    bus.abort         = 1'b0;
    repeat (3) cycle();

    $display("[TB] reset state");
    checkOutput("rst_step", bus.step, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_aborted", bus.aborted, 0);
    checkOutput("rst_pos", bus.cur_position, 0);
    checkOutput("rst_dir", bus.dir, 1);
    reset = 1'b0;
    cycle();
    monEnable = 1'b1;

    $display("[TB] move to +5, D=3");
    doneBase = doneCnt;
    applyStimulus(5, 5);
    checkOutput("t1_firstStep", bus.step, 1);
    checkOutput("t1_busy", bus.busy, 1);
    waitIdle("t1", 400);
    checkOutput("t1_pos", bus.cur_position, modelPos);
    checkOutput("t1_doneCount", doneCnt - doneBase, 1);
    checkOutput("t1_pulsesLeft", expQ.size(), 0);

    $display("[TB] move to -2 with inverted dir pin");
    bus.moveDirInvers = 1'b1;
    applyStimulus(-2, 7);
    checkOutput("t2_dirPin", bus.dir, 1);
    n = 1;
    while (bus.step !== 1'b1 && n < 200) begin
      cycle();
      n++;
    end
    checkOutput("t2_latency", n, DSC + 1);
    waitIdle("t2", 600);
    checkOutput("t2_pos", bus.cur_position, modelPos);
    checkOutput("t2_pulsesLeft", expQ.size(), 0);

    $display("[TB] zero-length move");
    doneBase = doneCnt;
    applyStimulus(-2, 0);
    checkOutput("t3_done", bus.done, 1);
    checkOutput("t3_busy", bus.busy, 0);
    checkOutput("t3_step", bus.step, 0);
    cycle();
    checkOutput("t3_doneDrop", bus.done, 0);
    checkOutput("t3_busyStill", bus.busy, 0);
    checkOutput("t3_doneCount", doneCnt - doneBase, 1);

    $display("[TB] abort during step 3 of 10");
    bus.moveDirInvers = 1'b0;
    doneBase  = doneCnt;
    abortBase = abortCnt;
    applyStimulus(8, 3);
    rises = 0;
    prevStep = 1'b0;
    n = 0;
    while (n < 2000) begin
      if (bus.step === 1'b1 && prevStep === 1'b0) rises++;
      if (rises == 3) break;
      prevStep = bus.step;
      cycle();
      n++;
    end
    checkOutput("t4_reachedStep3", rises, 3);
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    checkOutput("t4_stepHeld", bus.step, 1);
    waitIdle("t4", 400);
    checkOutput("t4_pos", bus.cur_position, modelPos);
    checkOutput("t4_abortCount", abortCnt - abortBase, 1);
    checkOutput("t4_doneCount", doneCnt - doneBase, 0);
    checkOutput("t4_pulsesLeft", expQ.size(), 0);

    $display("[TB] divider 0 treated as 1");
    bus.divider = '0;
    applyStimulus(3, 2);
    waitIdle("t5", 200);
    checkOutput("t5_pos", bus.cur_position, modelPos);
    checkOutput("t5_pulsesLeft", expQ.size(), 0);

    $display("[TB] tick enable one clock in four, D=1");
    bus.divider = DIV_W'(1);
    enaDiv = 1'b1;
    applyStimulus(6, 3);
    waitIdle("t6", 800);
    enaDiv = 1'b0;
    cycle();
    checkOutput("t6_pos", bus.cur_position, modelPos);
    checkOutput("t6_pulsesLeft", expQ.size(), 0);

    $display("[TB] reset in the middle of a move");
    monEnable = 1'b0;
    bus.divider = DIV_W'(3);
    applyStimulus(20, 0);
    cycle();
    checkOutput("t7_preResetStep", bus.step, 1);
    reset = 1'b1;
    cycle();
    checkOutput("t7_step", bus.step, 0);
    checkOutput("t7_pos", bus.cur_position, 0);
    checkOutput("t7_busy", bus.busy, 0);
    reset = 1'b0;
    modelPos = 0;
    expQ.delete();
    cycle();

    $display("[TB] position preset and its priority over target_load");
    bus.pos_value = -50;
    bus.pos_load  = 1'b1;
    cycle();
    bus.pos_load = 1'b0;
    checkOutput("t8_preset", bus.cur_position, -50);
    bus.pos_value   = 10;
    bus.target_pos  = 30;
    bus.pos_load    = 1'b1;
    bus.target_load = 1'b1;
    cycle();
    bus.pos_load    = 1'b0;
    bus.target_load = 1'b0;
    checkOutput("t8_presetWins", bus.cur_position, 10);
    checkOutput("t8_noMove", bus.busy, 0);
    modelPos = 10;
    cycle();

`ifdef MOTOR_RAMP_EN
    $display("[TB] ramped 6-step move");
    monEnable = 1'b1;
    applyStimulus(16, 6);
    waitIdle("t9", 800);
    checkOutput("t9_pos", bus.cur_position, modelPos);
    checkOutput("t9_pulsesLeft", expQ.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
